// File: rtl/rdclk_fifo_if.sv
// Bus bundle for rdclk_fifo: write/read requests from the master, data and status from the FIFO.
interface rdclk_fifo_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, ovf, udf
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/rdclk_fifo.sv
// Single-clock FIFO with registered read data, one-cycle read-valid pulse and sticky overflow/underflow flags.
module rdclk_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic         rdclk,
  input  logic         rst_n,
  rdclk_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d      = ovf_q || (bus.wr_en && full);
    udf_d      = udf_q || (bus.rd_en && empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately unreset; gating on rst_n drops a write that coincides with reset.
  always_ff @(posedge rdclk) begin
    if (wr_acc && rst_n) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule

// File: tb/tb_rdclk_fifo.sv
// Directed bench for rdclk_fifo: fill/drain, full/empty collisions, wrap-around and asynchronous reset.
module tb_rdclk_fifo;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;

  logic rdclk;
  logic rst_n;
  int   checks;
  int   failures;

  rdclk_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  rdclk_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .rdclk (rdclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of requests, then returns at the following falling edge to sample.
  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] data, input logic rd);
    bus.wr_en   = wr;
    bus.wr_data = data;
    bus.rd_en   = rd;
    @(posedge rdclk);
    @(negedge rdclk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    @(negedge rdclk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h00);
    checkOutput("rst_ovf_udf", {30'd0, bus.ovf, bus.udf}, 32'd0);
    @(negedge rdclk);
    rst_n = 1'b1;

    // Fill to full
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("fill_count1", 32'(bus.count), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    checkOutput("fill_count4", 32'(bus.count), 32'd4);
    checkOutput("fill_empty", 32'(bus.empty), 32'd0);
    checkOutput("fill_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("fill_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Collision at full: read wins, 0x55 is dropped
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("colfull_rd_data", 32'(bus.rd_data), 32'h11);
    checkOutput("colfull_rd_valid", 32'(bus.rd_valid), 32'd1);
    checkOutput("colfull_count", 32'(bus.count), 32'd3);
    checkOutput("colfull_ovf", 32'(bus.ovf), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("colfull_rd2", 32'(bus.rd_data), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("colfull_rd3", 32'(bus.rd_data), 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("colfull_rd4", 32'(bus.rd_data), 32'h44);
    checkOutput("colfull_drained", 32'(bus.empty), 32'd1);

    // Clean fill then drain in order
    resetDut();
    checkOutput("rst2_ovf", 32'(bus.ovf), 32'd0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_data", 32'(bus.rd_data), 32'(8'h11 * (i + 1)));
      checkOutput("drain_valid", 32'(bus.rd_valid), 32'd1);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    checkOutput("drain_count", 32'(bus.count), 32'd0);

    // Collision at empty: write wins, no fall-through
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("colempty_count", 32'(bus.count), 32'd1);
    checkOutput("colempty_udf", 32'(bus.udf), 32'd1);
    checkOutput("colempty_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("colempty_rd_data", 32'(bus.rd_data), 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("colempty_read", 32'(bus.rd_data), 32'hA5);
    checkOutput("colempty_read_valid", 32'(bus.rd_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_hold_data", 32'(bus.rd_data), 32'hA5);
    checkOutput("idle_valid_low", 32'(bus.rd_valid), 32'd0);

    // Steady state at count=2 across pointer wrap
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(i + 2), 1'b1);
      checkOutput("wrap_data", 32'(bus.rd_data), 32'(i));
      checkOutput("wrap_count", 32'(bus.count), 32'd2);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("wrap_tail10", 32'(bus.rd_data), 32'd10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("wrap_tail11", 32'(bus.rd_data), 32'd11);
    checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

    // Mid-stream asynchronous reset with count=3 and both flags set
    applyStimulus(1'b1, 8'h61, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0);
    applyStimulus(1'b1, 8'h64, 1'b0);
    applyStimulus(1'b1, 8'h65, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd3);
    checkOutput("pre_rst_flags", {30'd0, bus.ovf, bus.udf}, 32'd3);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h66;
    bus.rd_en   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(bus.count), 32'd0);
    checkOutput("async_rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("async_rst_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("async_rst_flags", {30'd0, bus.ovf, bus.udf}, 32'd0);
    @(negedge rdclk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checkOutput("held_rst_count", 32'(bus.count), 32'd0);
    rst_n = 1'b1;

    // First edge after reset release accepts a write
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("post_rst_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_data", 32'(bus.rd_data), 32'h77);
    checkOutput("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rdclk_fifo.md
RDCLK_FIFO -- requirements
Module: rdclk_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 2: pointer width; storage depth DEPTH = 2**ADDR_W (default 4).
REQ-003 SHALL provide port rdclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port wr_en  input  1  write request.
REQ-006 SHALL provide port wr_data  input  WIDTH  write word.
REQ-007 SHALL provide port rd_en  input  1  read request.
REQ-008 SHALL provide port rd_data  output  WIDTH  registered read word.
REQ-009 SHALL provide port rd_valid  output  1  one-cycle pulse, rd_data updated this cycle.
REQ-010 SHALL provide port full  output  1  count == DEPTH.
REQ-011 SHALL provide port empty  output  1  count == 0.
REQ-012 SHALL provide port count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 SHALL provide port ovf  output  1  sticky overflow flag.
REQ-014 SHALL provide port udf  output  1  sticky underflow flag.

Function
REQ-015 SHALL accept a write on a rising edge iff wr_en=1 and full=0 (full sampled before the edge); the accepted word is stored at the write pointer.
REQ-016 SHALL accept a read on a rising edge iff rd_en=1 and empty=0; the word at the read pointer is loaded into rd_data on that edge.
REQ-017 SHALL assert rd_valid for exactly the cycle following each accepted read; rd_valid=0 otherwise.
REQ-018 SHALL hold rd_data unchanged when no read is accepted.
REQ-019 SHALL keep read and write pointers ADDR_W+1 bits wide, each incremented modulo 2**(ADDR_W+1) on acceptance; storage index = low ADDR_W bits.
REQ-020 SHALL derive full, empty and count combinationally from registered pointers only (no input-to-output combinational path).
REQ-021 SHALL update count by +1 (write only), -1 (read only), 0 (both or neither) per edge.
REQ-022 Simultaneous wr_en and rd_en when 0 < count < DEPTH SHALL accept both; count unchanged.
REQ-023 Simultaneous wr_en and rd_en when full=1 SHALL accept the read, reject the write, set ovf; count becomes DEPTH-1.
REQ-024 Simultaneous wr_en and rd_en when empty=1 SHALL accept the write, reject the read, set udf; rd_valid stays 0 next cycle; count becomes 1 (no fall-through).
REQ-025 SHALL set ovf on any edge with wr_en=1 and full=1; SHALL set udf on any edge with rd_en=1 and empty=1; both remain 1 until reset.
REQ-026 A rejected access SHALL change no pointer, storage entry, rd_data or count.
REQ-027 SHALL preserve FIFO order across pointer wrap-around with no lost or duplicated words.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, clear both pointers, rd_data, rd_valid, ovf and udf, giving empty=1, full=0, count=0.
REQ-029 Storage contents SHALL need no reset; a write and read in flight when rst_n falls SHALL be discarded.
REQ-030 After rst_n rises, the first rdclk edge SHALL be able to accept a write.

Verification
REQ-031 Reset then write 0x11,0x22,0x33,0x44 on consecutive edges -> full=1, count=4, empty=0, ovf=0.
REQ-032 From full, rd_en four cycles -> rd_data 0x11,0x22,0x33,0x44 each with rd_valid=1 one cycle after its read; then empty=1, count=0.
REQ-033 From full, wr_en=1 and rd_en=1 with wr_data=0x55 -> rd_data=0x11, count=3, ovf=1, 0x55 never read out.
REQ-034 From empty, wr_en=1 (0xA5) and rd_en=1 -> count=1, udf=1, rd_valid=0; next read returns 0xA5.
REQ-035 Ten write/read pairs with data 0..9 at count=2 steady state -> outputs 0..9 in order across pointer wrap, count stays 2.
REQ-036 Drop rst_n mid-stream with count=3, between edges -> count=0, empty=1, rd_valid=0, ovf=udf=0 before next rdclk edge.
